// File: rtl/instr_enc_pkg.sv
// ---------------------------------------------------------------------------
// instr_enc_pkg
// Shared definitions for the MSP430 instruction encoder:
//   - instruction format codes (Format I, Format II, Jump)
//   - Format II opcode constants (RRC .. RETI)
//   - constant-generator / special register indices (R0, R2, R3)
//   - encoder FSM state encoding
//   - enc_opword(): builds the first (opcode) word of an instruction
// ---------------------------------------------------------------------------
package instr_enc_pkg;

    localparam logic [1:0] FMT_ILL = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_II  = 2'd2;
    localparam logic [1:0] FMT_J   = 2'd3;

    localparam logic [2:0] OP2_RRC  = 3'b000;
    localparam logic [2:0] OP2_SWPB = 3'b001;
    localparam logic [2:0] OP2_RRA  = 3'b010;
    localparam logic [2:0] OP2_SXT  = 3'b011;
    localparam logic [2:0] OP2_PUSH = 3'b100;
    localparam logic [2:0] OP2_CALL = 3'b101;
    localparam logic [2:0] OP2_RETI = 3'b110;
    localparam logic [2:0] OP2_BAD  = 3'b111;

    localparam logic [3:0] REG_R0 = 4'd0;
    localparam logic [3:0] REG_R2 = 4'd2;
    localparam logic [3:0] REG_R3 = 4'd3;

    localparam logic [15:0] RETI_WORD = 16'h1300;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OPW  = 3'd1,
        ST_SRCX = 3'd2,
        ST_DSTX = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Opcode word for a legal request. Illegal formats yield 0; the caller
    // never emits it in that case.
    function automatic logic [15:0] enc_opword(
        input logic [1:0] fmt,
        input logic [3:0] op,
        input logic [3:0] sa,
        input logic [3:0] da,
        input logic [1:0] as_m,
        input logic       ad,
        input logic       bw,
        input logic [9:0] off
    );
        logic [15:0] w;
        w = 16'h0000;
        case (fmt)
            FMT_I:  w = {op, sa, ad, bw, as_m, da};
            FMT_II: begin
                // RETI has no operand; its word is fixed regardless of fields.
                if (op[2:0] == OP2_RETI) w = RETI_WORD;
                else                     w = {6'b000100, op[2:0], bw, as_m, da};
            end
            FMT_J:  w = {3'b001, op[2:0], off};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_enc_if.sv
// ---------------------------------------------------------------------------
// instr_enc_if
// Request and word-stream bundle of the instruction encoder.
//   Request side : req_valid/req_ready plus the decoded instruction fields.
//   Word side    : MDB_in/word_valid/word_ready with word_first/word_last.
//   enc_err      : one-cycle pulse when a request is rejected as illegal.
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid && ready; once valid is high the producer holds valid and
// the payload stable until that transfer happens.
// Modports:
//   slave  - the encoder (consumes requests, produces words)
//   master - the requester / word consumer
// ---------------------------------------------------------------------------
interface instr_enc_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  FORMAT;
    logic [3:0]  OPCODE;
    logic [3:0]  reg_SA;
    logic [3:0]  reg_DA;
    logic [1:0]  As;
    logic        Ad;
    logic        BW;
    logic [9:0]  jmp_off;
    logic [15:0] src_ext;
    logic [15:0] dst_ext;
    logic [15:0] MDB_in;
    logic        word_valid;
    logic        word_ready;
    logic        word_first;
    logic        word_last;
    logic        enc_err;

    modport slave (
        input  req_valid, FORMAT, OPCODE, reg_SA, reg_DA, As, Ad, BW,
               jmp_off, src_ext, dst_ext, word_ready,
        output req_ready, MDB_in, word_valid, word_first, word_last, enc_err
    );

    modport master (
        output req_valid, FORMAT, OPCODE, reg_SA, reg_DA, As, Ad, BW,
               jmp_off, src_ext, dst_ext, word_ready,
        input  req_ready, MDB_in, word_valid, word_first, word_last, enc_err
    );
endinterface

// File: rtl/instr_enc_ext_need.sv
// ---------------------------------------------------------------------------
// instr_ext_need
// Combinational classification of a decoded instruction request.
// Ports:
//   format_i, opcode_i, reg_sa_i, reg_da_i, as_i, ad_i, bw_i : request fields
//   need_src_o : a source extension word follows the opcode word
//   need_dst_o : a destination extension word follows
//   illegal_o  : request cannot be encoded
// ---------------------------------------------------------------------------
module instr_ext_need
    import instr_enc_pkg::*;
(
    input  logic [1:0] format_i,
    input  logic [3:0] opcode_i,
    input  logic [3:0] reg_sa_i,
    input  logic [3:0] reg_da_i,
    input  logic [1:0] as_i,
    input  logic       ad_i,
    input  logic       bw_i,
    output logic       need_src_o,
    output logic       need_dst_o,
    output logic       illegal_o
);
    logic [3:0] src_reg;
    logic       ext_mode;

    // Format II carries its only operand in the destination register field.
    assign src_reg = (format_i == FMT_I) ? reg_sa_i : reg_da_i;

    // Indexed/symbolic/absolute (As=01 except the R3 constant) and
    // immediate (@PC+) both take an extension word.
    assign ext_mode = ((as_i == 2'b01) && (src_reg != REG_R3)) ||
                      ((as_i == 2'b11) && (src_reg == REG_R0));

    always_comb begin
        need_src_o = 1'b0;
        need_dst_o = 1'b0;
        illegal_o  = 1'b0;
        case (format_i)
            FMT_I: begin
                illegal_o  = (opcode_i < 4'd4);
                need_src_o = ext_mode;
                need_dst_o = ad_i;
            end
            FMT_II: begin
                illegal_o  = (opcode_i[2:0] == OP2_BAD) ||
                             (bw_i && ((opcode_i[2:0] == OP2_SWPB) ||
                                       (opcode_i[2:0] == OP2_SXT)  ||
                                       (opcode_i[2:0] == OP2_CALL)));
                need_src_o = ext_mode && (opcode_i[2:0] != OP2_RETI);
            end
            FMT_J: begin
                illegal_o = 1'b0;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/instr_enc.sv
// ---------------------------------------------------------------------------
// instr_enc
// MSP430 instruction encoder: accepts one decoded instruction request and
// emits its opcode word followed by any source and destination extension
// words, one word per handshake.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : instr_enc_if.slave (request channel, word stream, enc_err)
//   state_o : current FSM state (debug)
// ---------------------------------------------------------------------------
module instr_enc
    import instr_enc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    instr_enc_if.slave   bus,
    output state_t       state_o
);
    state_t      state_q, state_d;
    logic [15:0] mdb_q, mdb_d;
    logic [15:0] src_ext_q, dst_ext_q;
    logic        need_src_q, need_dst_q;
    logic        live_q;    // low until the first edge after reset release

    logic        need_src, need_dst, illegal;
    logic        accept, take;
    logic        req_ready, word_valid;
    logic [15:0] opword;

    instr_ext_need u_ext_need (
        .format_i   (bus.FORMAT),
        .opcode_i   (bus.OPCODE),
        .reg_sa_i   (bus.reg_SA),
        .reg_da_i   (bus.reg_DA),
        .as_i       (bus.As),
        .ad_i       (bus.Ad),
        .bw_i       (bus.BW),
        .need_src_o (need_src),
        .need_dst_o (need_dst),
        .illegal_o  (illegal)
    );

    assign opword = enc_opword(bus.FORMAT, bus.OPCODE, bus.reg_SA, bus.reg_DA,
                               bus.As, bus.Ad, bus.BW, bus.jmp_off);

    assign req_ready  = live_q && (state_q == ST_IDLE);
    assign word_valid = (state_q == ST_OPW) || (state_q == ST_SRCX) ||
                        (state_q == ST_DSTX);
    assign accept     = bus.req_valid && req_ready;
    assign take       = word_valid && bus.word_ready;

    // Next state and next word. MDB_in is loaded with the following word on
    // the same edge that takes the current one, so words stream back to back.
    always_comb begin
        state_d = state_q;
        mdb_d   = mdb_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        state_d = ST_ERR;
                        mdb_d   = 16'h0000;
                    end else begin
                        state_d = ST_OPW;
                        mdb_d   = opword;
                    end
                end
            end
            ST_OPW: begin
                if (take) begin
                    if (need_src_q) begin
                        state_d = ST_SRCX;
                        mdb_d   = src_ext_q;
                    end else if (need_dst_q) begin
                        state_d = ST_DSTX;
                        mdb_d   = dst_ext_q;
                    end else begin
                        state_d = ST_IDLE;
                        mdb_d   = 16'h0000;
                    end
                end
            end
            ST_SRCX: begin
                if (take) begin
                    if (need_dst_q) begin
                        state_d = ST_DSTX;
                        mdb_d   = dst_ext_q;
                    end else begin
                        state_d = ST_IDLE;
                        mdb_d   = 16'h0000;
                    end
                end
            end
            ST_DSTX: begin
                if (take) begin
                    state_d = ST_IDLE;
                    mdb_d   = 16'h0000;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                mdb_d   = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mdb_q      <= 16'h0000;
            src_ext_q  <= 16'h0000;
            dst_ext_q  <= 16'h0000;
            need_src_q <= 1'b0;
            need_dst_q <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            mdb_q   <= mdb_d;
            live_q  <= 1'b1;
            if (accept) begin
                src_ext_q  <= bus.src_ext;
                dst_ext_q  <= bus.dst_ext;
                need_src_q <= need_src && !illegal;
                need_dst_q <= need_dst && !illegal;
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.word_valid = word_valid;
    assign bus.MDB_in     = mdb_q;
    assign bus.word_first = (state_q == ST_OPW);
    assign bus.word_last  = ((state_q == ST_OPW)  && !need_src_q && !need_dst_q) ||
                            ((state_q == ST_SRCX) && !need_dst_q) ||
                            (state_q == ST_DSTX);
    assign bus.enc_err    = (state_q == ST_ERR);
    assign state_o        = state_q;
endmodule

// File: tb/tb_instr_enc.sv
// ---------------------------------------------------------------------------
// tb_instr_enc
// Directed bench for instr_enc: hand-encoded MSP430 instructions, word
// stream checks against an expected queue, backpressure, reset during an
// extension word, and illegal requests.
// ---------------------------------------------------------------------------
module tb_instr_enc;
    import instr_enc_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;

    instr_enc_if bus ();

    instr_enc dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [15:0] got,
                            input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for exactly one acceptance edge, then scrambles
    // the fields so any late sampling by the DUT shows up as a wrong word.
    task automatic send_req(input logic [1:0] fmt, input logic [3:0] op,
                            input logic [3:0] sa, input logic [3:0] da,
                            input logic [1:0] as_m, input logic ad,
                            input logic bw, input logic [9:0] off,
                            input logic [15:0] sx, input logic [15:0] dx);
        int w;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            step();
            w++;
        end
        check_eq("req_ready_wait", 16'(bus.req_ready), 16'd1);
        bus.FORMAT    = fmt;
        bus.OPCODE    = op;
        bus.reg_SA    = sa;
        bus.reg_DA    = da;
        bus.As        = as_m;
        bus.Ad        = ad;
        bus.BW        = bw;
        bus.jmp_off   = off;
        bus.src_ext   = sx;
        bus.dst_ext   = dx;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        bus.FORMAT    = 2'($urandom_range(0, 3));
        bus.OPCODE    = 4'($urandom_range(0, 15));
        bus.reg_SA    = 4'($urandom_range(0, 15));
        bus.reg_DA    = 4'($urandom_range(0, 15));
        bus.As        = 2'($urandom_range(0, 3));
        bus.Ad        = 1'($urandom_range(0, 1));
        bus.BW        = 1'($urandom_range(0, 1));
        bus.jmp_off   = 10'($urandom_range(0, 1023));
        bus.src_ext   = 16'($urandom_range(0, 65535));
        bus.dst_ext   = 16'($urandom_range(0, 65535));
    endtask

    // Consumes every word in exp_q, called right after send_req. Words must
    // appear with no bubble; at word index stall_idx the consumer withholds
    // word_ready for stall_cyc cycles and the word must hold.
    task automatic recv_instr(input string tag, input int stall_idx,
                              input int stall_cyc);
        int n;
        int w;
        logic [15:0] e;
        n = exp_q.size();
        w = 0;
        while (!bus.word_valid && w < 20) begin
            step();
            w++;
        end
        check_eq({tag, "_lat"}, 16'(w), 16'd0);
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            check_eq({tag, "_valid"}, 16'(bus.word_valid), 16'd1);
            check_eq({tag, "_word"},  bus.MDB_in, e);
            check_eq({tag, "_first"}, 16'(bus.word_first), 16'(i == 0));
            check_eq({tag, "_last"},  16'(bus.word_last), 16'(i == n - 1));
            if (i == stall_idx) begin
                bus.word_ready = 1'b0;
                for (int s = 0; s < stall_cyc; s++) begin
                    step();
                    check_eq({tag, "_hold_valid"}, 16'(bus.word_valid), 16'd1);
                    check_eq({tag, "_hold_word"},  bus.MDB_in, e);
                    check_eq({tag, "_hold_first"}, 16'(bus.word_first), 16'(i == 0));
                    check_eq({tag, "_hold_last"},  16'(bus.word_last), 16'(i == n - 1));
                end
            end
            bus.word_ready = 1'b1;
            step();
            bus.word_ready = 1'b0;
        end
        check_eq({tag, "_end_valid"}, 16'(bus.word_valid), 16'd0);
        check_eq({tag, "_end_rdy"},   16'(bus.req_ready), 16'd1);
    endtask

    // Called right after send_req of an illegal request.
    task automatic expect_err(input string tag);
        check_eq({tag, "_err"},      16'(bus.enc_err), 16'd1);
        check_eq({tag, "_valid"},    16'(bus.word_valid), 16'd0);
        check_eq({tag, "_rdy_low"},  16'(bus.req_ready), 16'd0);
        step();
        check_eq({tag, "_err_off"},  16'(bus.enc_err), 16'd0);
        check_eq({tag, "_valid2"},   16'(bus.word_valid), 16'd0);
        check_eq({tag, "_rdy_back"}, 16'(bus.req_ready), 16'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.FORMAT     = '0;
        bus.OPCODE     = '0;
        bus.reg_SA     = '0;
        bus.reg_DA     = '0;
        bus.As         = '0;
        bus.Ad         = 1'b0;
        bus.BW         = 1'b0;
        bus.jmp_off    = '0;
        bus.src_ext    = '0;
        bus.dst_ext    = '0;
        bus.word_ready = 1'b0;

        #23;
        check_eq("rst_req_ready",  16'(bus.req_ready), 16'd0);
        check_eq("rst_word_valid", 16'(bus.word_valid), 16'd0);
        check_eq("rst_mdb",        bus.MDB_in, 16'h0000);
        check_eq("rst_first",      16'(bus.word_first), 16'd0);
        check_eq("rst_last",       16'(bus.word_last), 16'd0);
        check_eq("rst_err",        16'(bus.enc_err), 16'd0);
        check_eq("rst_state",      16'(dbg_state), 16'(ST_IDLE));

        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_ready", 16'(bus.req_ready), 16'd1);

        // MOV R5,R6
        send_req(FMT_I, 4'h4, 4'd5, 4'd6, 2'b00, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0);
        exp_q.push_back(16'h4506);
        recv_instr("mov_rr", -1, 0);

        // MOV #0x1234,&0x0200
        send_req(FMT_I, 4'h4, 4'd0, 4'd2, 2'b11, 1'b1, 1'b0, 10'h0, 16'h1234, 16'h0200);
        exp_q.push_back(16'h40B2);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h0200);
        recv_instr("mov_imm_abs", -1, 0);

        // JNE +5
        send_req(FMT_J, 4'h0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 10'h005, 16'hAAAA, 16'h5555);
        exp_q.push_back(16'h2005);
        recv_instr("jne", -1, 0);

        // JMP -1
        send_req(FMT_J, 4'h7, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 10'h3FF, 16'h0, 16'h0);
        exp_q.push_back(16'h3FFF);
        recv_instr("jmp", -1, 0);

        // RETI with junk operand fields
        send_req(FMT_II, 4'h6, 4'd9, 4'd7, 2'b11, 1'b1, 1'b1, 10'h0, 16'hBEEF, 16'hCAFE);
        exp_q.push_back(16'h1300);
        recv_instr("reti", -1, 0);

        // PUSH #1 (constant generator R3, no extension)
        send_req(FMT_II, 4'h4, 4'd0, 4'd3, 2'b01, 1'b0, 1'b0, 10'h0, 16'hDEAD, 16'h0);
        exp_q.push_back(16'h1213);
        recv_instr("push_cg", -1, 0);

        // CALL #0xC000
        send_req(FMT_II, 4'h5, 4'd0, 4'd0, 2'b11, 1'b0, 1'b0, 10'h0, 16'hC000, 16'h0);
        exp_q.push_back(16'h12B0);
        exp_q.push_back(16'hC000);
        recv_instr("call_imm", -1, 0);

        // ADD.B 2(R4),R7 with backpressure on the extension word
        send_req(FMT_I, 4'h5, 4'd4, 4'd7, 2'b01, 1'b0, 1'b1, 10'h0, 16'h0002, 16'h0);
        exp_q.push_back(16'h5457);
        exp_q.push_back(16'h0002);
        recv_instr("add_idx_bp", 1, 4);

        // MOV R5,4(R6): destination extension only
        send_req(FMT_I, 4'h4, 4'd5, 4'd6, 2'b00, 1'b1, 1'b0, 10'h0, 16'h1111, 16'h0004);
        exp_q.push_back(16'h4586);
        exp_q.push_back(16'h0004);
        recv_instr("mov_dst_idx", -1, 0);

        // Reset while the source extension word is on the bus
        send_req(FMT_II, 4'h5, 4'd0, 4'd0, 2'b11, 1'b0, 1'b0, 10'h0, 16'hC000, 16'h0);
        check_eq("rst_mid_opw", bus.MDB_in, 16'h12B0);
        bus.word_ready = 1'b1;
        step();
        bus.word_ready = 1'b0;
        check_eq("rst_mid_srcx_state", 16'(dbg_state), 16'(ST_SRCX));
        check_eq("rst_mid_srcx_word",  bus.MDB_in, 16'hC000);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", 16'(bus.word_valid), 16'd0);
        check_eq("rst_mid_ready", 16'(bus.req_ready), 16'd0);
        check_eq("rst_mid_mdb",   bus.MDB_in, 16'h0000);
        #10;
        rst_n = 1'b1;
        step();
        check_eq("rst_mid_rel_valid", 16'(bus.word_valid), 16'd0);
        send_req(FMT_II, 4'h4, 4'd0, 4'd3, 2'b01, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0);
        exp_q.push_back(16'h1213);
        recv_instr("after_rst", -1, 0);

        // Illegal requests, each followed by a legal one
        send_req(FMT_ILL, 4'h4, 4'd5, 4'd6, 2'b00, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0);
        expect_err("ill_fmt0");
        send_req(FMT_I, 4'h4, 4'd5, 4'd6, 2'b00, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0);
        exp_q.push_back(16'h4506);
        recv_instr("ill_fmt0_next", -1, 0);

        send_req(FMT_I, 4'h2, 4'd5, 4'd6, 2'b00, 1'b1, 1'b0, 10'h0, 16'h0, 16'h0);
        expect_err("ill_f1_op2");
        send_req(FMT_J, 4'h7, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 10'h3FF, 16'h0, 16'h0);
        exp_q.push_back(16'h3FFF);
        recv_instr("ill_f1_next", -1, 0);

        send_req(FMT_II, 4'h3, 4'd0, 4'd4, 2'b00, 1'b0, 1'b1, 10'h0, 16'h0, 16'h0);
        expect_err("ill_sxt_b");
        send_req(FMT_II, 4'h6, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0);
        exp_q.push_back(16'h1300);
        recv_instr("ill_sxt_next", -1, 0);

        send_req(FMT_II, 4'h7, 4'd0, 4'd4, 2'b00, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0);
        expect_err("ill_f2_op7");

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/instr_enc.md
Name: instr_enc

Overview:
- Builds MSP430 instruction streams from decoded fields. It is the inverse of the instruction decoder.
- Accepts one instruction request, made of format, opcode, registers, addressing modes and extension values. Emits the opcode word, then any source and destination extension words, one per handshake on a 16-bit MDB-style word stream.
- Used by the ROM/boot loader path and by benches that drive the decoder with legal, self-consistent streams.

Parameters:
- None. Word width is fixed at 16 by the ISA.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  encoder idle; request accepted on req_valid && req_ready
- FORMAT  in  2  1=Format I, 2=Format II, 3=Jump, 0=illegal
- OPCODE  in  4  Fmt I: word[15:12]; Fmt II: [2:0] = word[9:7]; Jump: [2:0] = condition, word[12:10]
- reg_SA  in  4  source register (Fmt I only)
- reg_DA  in  4  destination register (Fmt I); operand register (Fmt II)
- As  in  2  source/operand addressing mode
- Ad  in  1  destination addressing mode (Fmt I)
- BW  in  1  byte/word select
- jmp_off  in  10  signed word offset (Jump)
- src_ext  in  16  source extension word value
- dst_ext  in  16  destination extension word value
- MDB_in  out  16  emitted word
- word_valid  out  1  MDB_in valid
- word_ready  in  1  consumer takes word on word_valid && word_ready
- word_first  out  1  current word is the opcode word
- word_last  out  1  current word is the final word of the instruction
- enc_err  out  1  one-cycle pulse: request rejected as illegal

Behaviour:
- Clock is clk. Reset is asynchronous, active-low rst_n. While rst_n=0 all outputs are 0 except req_ready, which is also 0. State is IDLE.
- From the first clk edge after reset release, req_ready=1 in IDLE.
- Request fields are latched on acceptance and are not sampled again.
- Encoding:
  - Fmt I: {OPCODE, reg_SA, Ad, BW, As, reg_DA}.
  - Fmt II: {6'b000100, OPCODE[2:0], BW, As, reg_DA}. RETI (OPCODE=110) is forced to 0x1300.
  - Jump: {3'b001, OPCODE[2:0], jmp_off}.
- Source extension (Fmt I uses reg_SA; Fmt II uses reg_DA) is needed when:
  - As=01 and reg≠R3, or
  - As=11 and reg=R0.
- Destination extension is needed only for Fmt I with Ad=1.
- Jump and RETI produce exactly one word.
- Illegal requests:
  - FORMAT=0,
  - Fmt I with OPCODE<4,
  - Fmt II with OPCODE=111,
  - BW=1 with SWPB, SXT or CALL.
- On an illegal request: enc_err=1 the cycle after acceptance, no word is emitted, and the block returns to IDLE.
- FSM states:
  - IDLE: req_ready=1. On accept, go to ERR if illegal, else OPW.
  - OPW: present the opcode word with word_first=1. On take, go to SRCX if a source extension is needed, else DSTX if a destination extension is needed, else IDLE.
  - SRCX: present src_ext. On take, go to DSTX if needed, else IDLE.
  - DSTX: present dst_ext. On take, go to IDLE.
  - ERR: single cycle, go to IDLE.
- Latency and throughput:
  - word_valid rises the cycle after acceptance.
  - Consecutive words have no bubbles. MDB_in is a register updated on the same edge that takes the previous word.
  - One idle cycle separates instructions, because req_ready is high only in IDLE.
- Handshake:
  - While word_valid=1 and word_ready=0, MDB_in, word_first and word_last hold stable.
  - word_valid never drops without a take.
  - word_last=1 on the final word, including single-word instructions, where word_first=word_last=1.
- Reset mid-instruction: remaining words are discarded; the stream restarts clean with no partial instruction.

Decomposition:
- Add to msp430_ops.vh: format codes (FMT_I=1, FMT_II=2, FMT_J=3), Fmt II opcode constants (RRC..RETI), CG register indices (R0, R2, R3), and FSM state encodings.
- One combinational sub-module, instr_ext_need. It takes FORMAT, OPCODE, reg_SA, reg_DA, As and Ad, and returns need_src, need_dst and illegal. The decoder bench reuses it as a reference.

Test Plan:
- MOV R5,R6 (F=1, OP=4, SA=5, DA=6, As=00, Ad=0) -> single word 0x4506 with first=last=1; req_ready back high after take.
- MOV #0x1234,&0x0200 (OP=4, SA=0, As=11, Ad=1, DA=2), word_ready held 1 -> 0x40B2, 0x1234, 0x0200 on three consecutive cycles, last only on 0x0200.
- JNE off=0x005 -> 0x2005. JMP (cond 111) off=0x3FF -> 0x3FFF. RETI -> 0x1300. Each is one word.
- PUSH #1 (F=2, OP=100, As=01, reg R3) -> 0x1213 with no extension. CALL #0xC000 (OP=101, As=11, reg R0) -> 0x12B0 then 0xC000.
- Backpressure and reset: word_ready low for 4 cycles on the second word -> MDB_in stable throughout. rst_n asserted during SRCX -> word_valid=0 immediately, and the next request restarts at OPW.
- Illegal: FORMAT=0, Fmt I OP=2, SXT with BW=1 -> enc_err pulses for exactly one cycle, word_valid stays 0, and the next legal request encodes correctly.
